// File: rtl/cipu_stream_tx.sv
// Transmit-side source for the CIPU check-in protocol: buffers a people sequence and a
// grouped luggage sequence, then replays both as ASCII streams with ready/done handshakes.
module cipu_stream_tx #(
  parameter int PDEPTH = 32,
  parameter int LDEPTH = 32,
  parameter int GMAX   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_wr,
  input  logic [7:0] p_data,
  input  logic       l_wr,
  input  logic [7:0] l_data,
  input  logic       l_sep,
  input  logic [3:0] l_num,
  input  logic       start,
  input  logic       done_thing,
  input  logic       done_fifo,
  input  logic       done_fifo2,
  output logic       ready_fifo,
  output logic       ready_lifo,
  output logic [7:0] people_thing_in,
  output logic [7:0] thing_in,
  output logic [3:0] thing_num,
  output logic       busy,
  output logic       tx_done,
  output logic       ovf
);

  localparam int PW  = $clog2(PDEPTH + 1);
  localparam int LW  = $clog2(LDEPTH + 1);
  localparam int GW  = $clog2(GMAX + 1);
  localparam int PIW = (PDEPTH > 1) ? $clog2(PDEPTH) : 1;
  localparam int LIW = (LDEPTH > 1) ? $clog2(LDEPTH) : 1;
  localparam int GIW = (GMAX > 1) ? $clog2(GMAX) : 1;
  localparam int CW  = (LW > 4) ? LW : 4;

  localparam logic [PW-1:0] P_MAX = PW'(PDEPTH);
  localparam logic [LW-1:0] L_MAX = LW'(LDEPTH);
  localparam logic [GW-1:0] G_MAX = GW'(GMAX);

  localparam logic [2:0] P_IDLE = 3'd0;
  localparam logic [2:0] P_RDY  = 3'd1;
  localparam logic [2:0] P_SEND = 3'd2;
  localparam logic [2:0] P_END  = 3'd3;
  localparam logic [2:0] P_WAIT = 3'd4;

  localparam logic [2:0] L_IDLE  = 3'd0;
  localparam logic [2:0] L_RDY   = 3'd1;
  localparam logic [2:0] L_SEND  = 3'd2;
  localparam logic [2:0] L_SEP   = 3'd3;
  localparam logic [2:0] L_WAITT = 3'd4;
  localparam logic [2:0] L_GAP   = 3'd5;
  localparam logic [2:0] L_END   = 3'd6;
  localparam logic [2:0] L_WAIT  = 3'd7;

  logic [7:0]    r_pBuf [PDEPTH];
  logic [7:0]    r_lBuf [LDEPTH];
  logic [LW-1:0] r_gLen [GMAX];
  logic [3:0]    r_gNum [GMAX];

  logic [PW-1:0] r_pCount;
  logic [LW-1:0] r_lCount;
  logic [GW-1:0] r_gCount;
  logic [LW-1:0] r_lGrpStart;
  logic          r_busy;
  logic          r_txDone;
  logic          r_ovf;
  logic          r_startPend;

  logic [2:0]    r_pState;
  logic [PW-1:0] r_pRd;
  logic          r_pDone;

  logic [2:0]    r_lState;
  logic [LW-1:0] r_lRd;
  logic [GW-1:0] r_gIdx;
  logic [LW-1:0] r_dCnt;
  logic          r_lDone;

  logic          w_anyWr;
  logic          w_go;
  logic          w_finish;
  logic          w_pWrOk;
  logic          w_lWrOk;
  logic          w_sepOk;
  logic [LW-1:0] w_lCntNext;
  logic [LW-1:0] w_grpLen;
  logic          w_numClamp;
  logic [3:0]    w_sepNum;
  logic          w_ovfHit;
  logic          w_inGrp;
  logic [GIW-1:0] w_gi;
  logic [LW-1:0] w_curLen;
  logic [3:0]    w_curNum;
  logic [2:0]    w_lNext;

  // A start that coincides with a write is deferred one cycle so the write lands first.
  assign w_anyWr    = p_wr | l_wr | l_sep;
  assign w_go       = !r_busy && (r_startPend || (start && !w_anyWr));
  assign w_finish   = r_busy && r_pDone && r_lDone;
  assign w_pWrOk    = !r_busy && p_wr && (r_pCount < P_MAX);
  assign w_lWrOk    = !r_busy && l_wr && (r_lCount < L_MAX);
  assign w_sepOk    = !r_busy && l_sep && (r_gCount < G_MAX);
  assign w_lCntNext = r_lCount + LW'(w_lWrOk);
  assign w_grpLen   = w_lCntNext - r_lGrpStart;
  assign w_numClamp = CW'(l_num) > CW'(w_grpLen);
  assign w_sepNum   = w_numClamp ? 4'(w_grpLen) : l_num;
  assign w_ovfHit   = !r_busy && ((p_wr && !(r_pCount < P_MAX)) ||
                                  (l_wr && !(r_lCount < L_MAX)) ||
                                  (l_sep && (!(r_gCount < G_MAX) || w_numClamp)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pCount    <= '0;
      r_lCount    <= '0;
      r_gCount    <= '0;
      r_lGrpStart <= '0;
      r_busy      <= 1'b0;
      r_txDone    <= 1'b0;
      r_ovf       <= 1'b0;
      r_startPend <= 1'b0;
    end else begin
      r_txDone <= w_finish;
      if (w_ovfHit) r_ovf <= 1'b1;
      if (!r_busy) r_startPend <= !w_go && start && w_anyWr;
      if (w_finish) begin
        r_busy      <= 1'b0;
        r_pCount    <= '0;
        r_lCount    <= '0;
        r_gCount    <= '0;
        r_lGrpStart <= '0;
      end else begin
        if (w_go) r_busy <= 1'b1;
        if (w_pWrOk) r_pCount <= r_pCount + 1'b1;
        if (w_lWrOk) r_lCount <= w_lCntNext;
        if (w_sepOk) begin
          r_gCount    <= r_gCount + 1'b1;
          r_lGrpStart <= w_lCntNext;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_pWrOk) r_pBuf[r_pCount[PIW-1:0]] <= p_data;
    if (w_lWrOk) r_lBuf[r_lCount[LIW-1:0]] <= l_data;
    if (w_sepOk) begin
      r_gLen[r_gCount[GIW-1:0]] <= w_grpLen;
      r_gNum[r_gCount[GIW-1:0]] <= w_sepNum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pState <= P_IDLE;
      r_pRd    <= '0;
      r_pDone  <= 1'b0;
    end else if (w_finish) begin
      r_pState <= P_IDLE;
      r_pDone  <= 1'b0;
    end else begin
      case (r_pState)
        P_IDLE: if (w_go) begin
          r_pState <= P_RDY;
          r_pRd    <= '0;
        end
        P_RDY:  r_pState <= (r_pCount == '0) ? P_END : P_SEND;
        P_SEND: begin
          r_pRd <= r_pRd + 1'b1;
          if (r_pRd + 1'b1 == r_pCount) r_pState <= P_END;
        end
        P_END:  r_pState <= P_WAIT;
        P_WAIT: if (done_fifo) begin
          r_pDone  <= 1'b1;
          r_pState <= P_IDLE;
        end
        default: r_pState <= P_IDLE;
      endcase
    end
  end

  // Groups below r_gCount were closed by l_sep; anything past them is the final group.
  assign w_inGrp  = r_gIdx < r_gCount;
  assign w_gi     = r_gIdx[GIW-1:0];
  assign w_curLen = r_gLen[w_gi];
  assign w_curNum = r_gNum[w_gi];

  always_comb begin
    w_lNext = L_END;
    if (w_inGrp) w_lNext = (w_curLen == '0) ? L_SEP : L_SEND;
    else if (r_lRd < r_lCount) w_lNext = L_SEND;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lState <= L_IDLE;
      r_lRd    <= '0;
      r_gIdx   <= '0;
      r_dCnt   <= '0;
      r_lDone  <= 1'b0;
    end else if (w_finish) begin
      r_lState <= L_IDLE;
      r_lDone  <= 1'b0;
    end else begin
      case (r_lState)
        L_IDLE: if (w_go) begin
          r_lState <= L_RDY;
          r_lRd    <= '0;
          r_gIdx   <= '0;
          r_dCnt   <= '0;
        end
        L_RDY:   r_lState <= w_lNext;
        L_SEND: begin
          r_lRd  <= r_lRd + 1'b1;
          r_dCnt <= r_dCnt + 1'b1;
          if (w_inGrp) begin
            if (r_dCnt + 1'b1 == w_curLen) r_lState <= L_SEP;
          end else if (r_lRd + 1'b1 == r_lCount) begin
            r_lState <= L_END;
          end
        end
        L_SEP: begin
          r_lState <= L_WAITT;
          r_dCnt   <= '0;
        end
        L_WAITT: if (done_thing) begin
          r_gIdx   <= r_gIdx + 1'b1;
          r_lState <= L_GAP;
        end
        L_GAP:   r_lState <= w_lNext;
        L_END:   r_lState <= L_WAIT;
        L_WAIT:  if (done_fifo2) begin
          r_lDone  <= 1'b1;
          r_lState <= L_IDLE;
        end
        default: r_lState <= L_IDLE;
      endcase
    end
  end

  always_comb begin
    people_thing_in = 8'h20;
    case (r_pState)
      P_SEND:  people_thing_in = r_pBuf[r_pRd[PIW-1:0]];
      P_END:   people_thing_in = 8'h24;
      default: people_thing_in = 8'h20;
    endcase
  end

  always_comb begin
    thing_in  = 8'h20;
    thing_num = 4'd0;
    case (r_lState)
      L_SEND:  thing_in = r_lBuf[r_lRd[LIW-1:0]];
      L_SEP:   thing_in = 8'h3B;
      L_END:   thing_in = 8'h24;
      default: thing_in = 8'h20;
    endcase
    if (w_inGrp && (r_lState == L_SEND || r_lState == L_SEP || r_lState == L_WAITT))
      thing_num = w_curNum;
  end

  assign ready_fifo = (r_pState == P_RDY);
  assign ready_lifo = (r_lState == L_RDY);
  assign busy       = r_busy;
  assign tx_done    = r_txDone;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_cipu_stream_tx.sv
// Randomized bench for cipu_stream_tx: a queue-based model lays out the expected
// per-cycle streams of each exchange and one process compares the DUT against it.
`timescale 1ns/1ps
module tb_cipu_stream_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       p_wr, l_wr, l_sep, start;
  logic [7:0] p_data, l_data;
  logic [3:0] l_num;
  logic       done_thing, done_fifo, done_fifo2;
  logic       ready_fifo, ready_lifo, busy, tx_done, ovf;
  logic [7:0] people_thing_in, thing_in;
  logic [3:0] thing_num;

  always #5 clk = ~clk;

  cipu_stream_tx #(.PDEPTH(32), .LDEPTH(32), .GMAX(8)) dut (
    .clk(clk), .rst(rst),
    .p_wr(p_wr), .p_data(p_data),
    .l_wr(l_wr), .l_data(l_data), .l_sep(l_sep), .l_num(l_num),
    .start(start),
    .done_thing(done_thing), .done_fifo(done_fifo), .done_fifo2(done_fifo2),
    .ready_fifo(ready_fifo), .ready_lifo(ready_lifo),
    .people_thing_in(people_thing_in), .thing_in(thing_in), .thing_num(thing_num),
    .busy(busy), .tx_done(tx_done), .ovf(ovf)
  );

  // One entry per cycle: expected outputs, done pulses to drive, and whether a done is listened to.
  typedef struct {
    bit         rdy;
    logic [7:0] ch;
    logic [3:0] num;
    bit         dA;
    bit         dB;
    bit         sA;
    bit         sB;
  } step_t;

  step_t pq[$];
  step_t lq[$];

  byte unsigned mP[$];
  byte unsigned mL[$];
  int           mGLen[$];
  int           mGNum[$];
  int           mGrpStart = 0;
  bit           mOvf = 1'b0;

  int total = 0;
  int bad   = 0;
  bit chkEn = 1'b0;

  logic       eRf, eRl, eBusy, eTx, eOvf;
  logic [7:0] ePc, eTc;
  logic [3:0] eTn;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("ready_fifo", ready_fifo, eRf);
      checkOutput("ready_lifo", ready_lifo, eRl);
      checkOutput("people_thing_in", people_thing_in, ePc);
      checkOutput("thing_in", thing_in, eTc);
      checkOutput("thing_num", thing_num, eTn);
      checkOutput("busy", busy, eBusy);
      checkOutput("tx_done", tx_done, eTx);
      checkOutput("ovf", ovf, eOvf);
    end
  end

  function automatic step_t mk(bit rdy, logic [7:0] ch, logic [3:0] num,
                               bit dA, bit dB, bit sA, bit sB);
    step_t s;
    s.rdy = rdy; s.ch = ch; s.num = num; s.dA = dA; s.dB = dB; s.sA = sA; s.sB = sB;
    return s;
  endfunction

  task automatic setIdleExp();
    eRf = 0; eRl = 0; ePc = 8'h20; eTc = 8'h20; eTn = 0; eBusy = 0; eTx = 0; eOvf = mOvf;
  endtask

  task automatic clearModel(input bit withOvf);
    mP.delete(); mL.delete(); mGLen.delete(); mGNum.delete();
    mGrpStart = 0;
    if (withOvf) mOvf = 1'b0;
  endtask

  task automatic applyStimulus(input bit pw, input byte unsigned pd, input bit lw,
                               input byte unsigned ld, input bit ls, input logic [3:0] ln,
                               input bit st);
    @(posedge clk); #1;
    setIdleExp();
    p_wr = pw; p_data = pd; l_wr = lw; l_data = ld; l_sep = ls; l_num = ln; start = st;
    done_thing = 0; done_fifo = 0; done_fifo2 = 0;
  endtask

  task automatic pushP(input byte unsigned ch);
    applyStimulus(1, ch, 0, 0, 0, 0, 0);
    if (mP.size() < 32) mP.push_back(ch); else mOvf = 1;
  endtask

  task automatic pushL(input byte unsigned d);
    applyStimulus(0, 0, 1, d, 0, 0, 0);
    if (mL.size() < 32) mL.push_back(d); else mOvf = 1;
  endtask

  task automatic closeGroup(input int n);
    int len;
    applyStimulus(0, 0, 0, 0, 1, 4'(n), 0);
    if (mGLen.size() < 8) begin
      len = mL.size() - mGrpStart;
      if (n > len) mOvf = 1;
      mGLen.push_back(len);
      mGNum.push_back((n > len) ? len : n);
      mGrpStart = mL.size();
    end else begin
      mOvf = 1;
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ready_fifo"}, ready_fifo, 0);
    checkOutput({tag, "_ready_lifo"}, ready_lifo, 0);
    checkOutput({tag, "_people"}, people_thing_in, 8'h20);
    checkOutput({tag, "_thing_in"}, thing_in, 8'h20);
    checkOutput({tag, "_thing_num"}, thing_num, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_tx_done"}, tx_done, 0);
    checkOutput({tag, "_ovf"}, ovf, 0);
  endtask

  task automatic resetDut();
    @(posedge clk); #1;
    chkEn = 0;
    p_wr = 0; l_wr = 0; l_sep = 0; start = 0; done_thing = 0; done_fifo = 0; done_fifo2 = 0;
    rst = 1; #3;
    checkReset("rst");
    @(posedge clk); #1;
    rst = 0;
    clearModel(1);
    setIdleExp();
    chkEn = 1;
  endtask

  // Cycle 0 carries start; cycle 1 is the ready pulse on both streams.
  task automatic buildExpect(output int lastC);
    int pos;
    int w;
    logic [3:0] n;
    pq.delete(); lq.delete();
    pq.push_back(mk(0, 8'h20, 0, 0, 0, 0, 0)); lq.push_back(mk(0, 8'h20, 0, 0, 0, 0, 0));
    pq.push_back(mk(1, 8'h20, 0, 0, 0, 0, 0)); lq.push_back(mk(1, 8'h20, 0, 0, 0, 0, 0));
    foreach (mP[i]) pq.push_back(mk(0, mP[i], 0, 0, 0, 0, 0));
    pq.push_back(mk(0, 8'h24, 0, 0, 0, 0, 0));
    w = $urandom_range(0, 3);
    repeat (w) pq.push_back(mk(0, 8'h20, 0, 0, 0, 1, 0));
    pq.push_back(mk(0, 8'h20, 0, 1, 0, 1, 0));
    pos = 0;
    for (int g = 0; g < mGLen.size(); g++) begin
      n = 4'(mGNum[g]);
      for (int j = 0; j < mGLen[g]; j++) begin
        lq.push_back(mk(0, mL[pos], n, 0, 0, 0, 0));
        pos++;
      end
      lq.push_back(mk(0, 8'h3B, n, 0, 0, 0, 0));
      w = $urandom_range(0, 3);
      repeat (w) lq.push_back(mk(0, 8'h20, n, 0, 0, 1, 0));
      lq.push_back(mk(0, 8'h20, n, 1, 0, 1, 0));
      lq.push_back(mk(0, 8'h20, 0, 0, 0, 0, 0));
    end
    while (pos < mL.size()) begin
      lq.push_back(mk(0, mL[pos], 0, 0, 0, 0, 0));
      pos++;
    end
    lq.push_back(mk(0, 8'h24, 0, 0, 0, 0, 0));
    w = $urandom_range(0, 3);
    repeat (w) lq.push_back(mk(0, 8'h20, 0, 0, 0, 0, 1));
    lq.push_back(mk(0, 8'h20, 0, 0, 1, 0, 1));
    lastC = ((pq.size() > lq.size()) ? pq.size() : lq.size()) - 1;
    while (pq.size() < lastC + 4) pq.push_back(mk(0, 8'h20, 0, 0, 0, 0, 0));
    while (lq.size() < lastC + 4) lq.push_back(mk(0, 8'h20, 0, 0, 0, 0, 0));
  endtask

  task automatic runTx(input int abortAt);
    int m;
    bit nz;
    buildExpect(m);
    for (int c = 0; c <= m + 3; c++) begin
      @(posedge clk); #1;
      p_wr = 0; l_wr = 0; l_sep = 0; start = (c == 0);
      if (c >= 1 && c <= m + 1 && $urandom_range(0, 7) == 0) begin
        start = 1;
        p_wr = 1'($urandom_range(0, 1)); p_data = 8'h5A;
        l_wr = 1'($urandom_range(0, 1)); l_data = 8'h39;
        l_sep = 1'($urandom_range(0, 1)); l_num = 4'($urandom_range(0, 15));
      end
      nz = ($urandom_range(0, 3) == 0);
      done_fifo  = pq[c].dA | (!pq[c].sA && nz);
      done_thing = lq[c].dA | (!lq[c].sA && nz);
      done_fifo2 = lq[c].dB | (!lq[c].sB && ($urandom_range(0, 3) == 0));
      eRf = pq[c].rdy; ePc = pq[c].ch;
      eRl = lq[c].rdy; eTc = lq[c].ch; eTn = lq[c].num;
      eBusy = (c >= 1 && c <= m + 1); eTx = (c == m + 2); eOvf = mOvf;
      if (c == abortAt) begin
        #2;
        chkEn = 0;
        p_wr = 0; l_wr = 0; l_sep = 0; start = 0;
        done_thing = 0; done_fifo = 0; done_fifo2 = 0;
        rst = 1; #1;
        checkReset("abort");
        @(posedge clk); #1;
        rst = 0;
        clearModel(1);
        setIdleExp();
        chkEn = 1;
        return;
      end
    end
    clearModel(0);
  endtask

  function automatic byte unsigned rndP();
    if ($urandom_range(0, 2) == 0) return 8'(8'h31 + $urandom_range(0, 8));
    return 8'(8'h41 + $urandom_range(0, 25));
  endfunction

  initial begin
    p_wr = 0; l_wr = 0; l_sep = 0; start = 0; p_data = 0; l_data = 0; l_num = 0;
    done_thing = 0; done_fifo = 0; done_fifo2 = 0;
    rst = 1;
    setIdleExp();
    #12;
    checkReset("init");
    @(posedge clk); #1;
    rst = 0;
    chkEn = 1;

    $display("[TB] people AB1C, empty luggage");
    pushP(8'h41); pushP(8'h42); pushP(8'h31); pushP(8'h43);
    runTx(-1);
    checkOutput("pin_p_rdy", pq[1].rdy, 1);
    checkOutput("pin_p2", pq[2].ch, 8'h41);
    checkOutput("pin_p3", pq[3].ch, 8'h42);
    checkOutput("pin_p4", pq[4].ch, 8'h31);
    checkOutput("pin_p5", pq[5].ch, 8'h43);
    checkOutput("pin_p6", pq[6].ch, 8'h24);
    checkOutput("pin_l2", lq[2].ch, 8'h24);

    $display("[TB] luggage 123;2 then 45");
    pushL(8'h31); pushL(8'h32); pushL(8'h33); closeGroup(2); pushL(8'h34); pushL(8'h35);
    runTx(-1);
    checkOutput("pin_l2_ch", lq[2].ch, 8'h31);
    checkOutput("pin_l4_ch", lq[4].ch, 8'h33);
    checkOutput("pin_l5_sep", lq[5].ch, 8'h3B);
    checkOutput("pin_l2_num", lq[2].num, 2);
    checkOutput("ovf_before_clamp", ovf, 0);

    $display("[TB] clamp l_num=5 over two digits");
    pushL(8'h37); pushL(8'h38); closeGroup(5);
    runTx(-1);
    checkOutput("pin_clamp_num", lq[2].num, 2);
    checkOutput("ovf_after_clamp", ovf, 1);

    $display("[TB] empty group");
    closeGroup(0);
    runTx(-1);
    checkOutput("pin_empty_sep", lq[2].ch, 8'h3B);
    checkOutput("pin_empty_num", lq[2].num, 0);

    $display("[TB] people overflow");
    resetDut();
    for (int i = 0; i < 33; i++) pushP(rndP());
    runTx(-1);
    checkOutput("pin_p34_end", pq[34].ch, 8'h24);
    checkOutput("ovf_people_full", ovf, 1);

    $display("[TB] reset during luggage send");
    pushL(8'h31); pushL(8'h32); pushL(8'h33); closeGroup(2); pushL(8'h34);
    pushP(8'h50);
    runTx(3);
    pushP(8'h39); pushP(8'h5A); pushL(8'h37); pushL(8'h38); closeGroup(1); pushL(8'h36);
    runTx(-1);
    runTx(-1);

    $display("[TB] random exchanges");
    for (int t = 0; t < 10; t++) begin
      int np;
      int ng;
      if ($urandom_range(0, 3) == 0) resetDut();
      np = $urandom_range(0, 34);
      for (int i = 0; i < np; i++) pushP(rndP());
      ng = $urandom_range(0, 9);
      for (int g = 0; g < ng; g++) begin
        int nd;
        nd = $urandom_range(0, 4);
        for (int j = 0; j < nd; j++) pushL(8'(8'h31 + $urandom_range(0, 8)));
        closeGroup($urandom_range(0, 9));
      end
      for (int j = 0; j < $urandom_range(0, 3); j++) pushL(8'(8'h31 + $urandom_range(0, 8)));
      runTx(-1);
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chkEn = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
